// File: rtl/fib2glb_pkg.sv
// ---------------------------------------------------------------------------
// fib2glb_pkg
//   Shared definitions for the fiber-to-GLB segment packer:
//   - FLAG_BIT   : index of the control flag inside a 17-bit fiber token
//   - DONE_TOKEN : the one control token that terminates the whole stream
//   - state_e    : packer FSM states
//   - is_stop()  : recognises a stop token (flag set, bits[15:8] zero);
//                  the stop level in bits[7:0] is irrelevant here
// ---------------------------------------------------------------------------
package fib2glb_pkg;

    localparam int          FLAG_BIT   = 16;
    localparam logic [16:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [2:0] {
        FILL,
        EMIT_LEN,
        EMIT_DATA,
        EMIT_DONE,
        HALT
    } state_e;

    function automatic logic is_stop(input logic [16:0] tok);
        return tok[FLAG_BIT] && (tok[15:8] == 8'h00);
    endfunction

endpackage

// File: rtl/fib2glb_seg_buf.sv
// ---------------------------------------------------------------------------
// fib2glb_seg_buf
//   DEPTH x 16-bit segment buffer: one synchronous write port and one
//   combinational read port. Contents are not reset; the packer's word
//   count decides which entries are meaningful.
//
// Ports:
//   clk_i     clock
//   clk_en_i  clock enable; writes only happen while it is high
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write data (payload bits of a data token)
//   raddr_i   read address
//   rdata_o   read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module fib2glb_seg_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          clk_en_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (clk_en_i && we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fib2glb_seg_packer.sv
// ---------------------------------------------------------------------------
// fib2glb_seg_packer
//   Converts a fiber token stream (data words + stop/done control tokens)
//   into length-prefixed segments for the write scanner's block input:
//   a word count first, then the buffered data words in arrival order,
//   and finally the done token once the stream has ended.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clk_en           clock enable; every register holds while low
//   flush            synchronous clear, same effect as reset
//   tile_en          block enable; forces both handshakes off while low
//   data_in*         token input from the read scanner (valid/ready)
//   data_out*        segment words toward the GLB (valid/ready)
//   overflow         sticky: a segment held more than DEPTH words
//   done             the done token has been emitted
// ---------------------------------------------------------------------------
module fib2glb_seg_packer
    import fib2glb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DW    = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic          flush,
    input  logic          tile_en,
    input  logic [DW-1:0] data_in,
    input  logic          data_in_valid,
    output logic          data_in_ready,
    output logic [DW-1:0] data_out,
    output logic          data_out_valid,
    input  logic          data_out_ready,
    output logic          overflow,
    output logic          done
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dvalid_q, dvalid_d;

    logic          in_hs, out_hs;
    logic          buf_we;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic [DW-1:0] header_word;
    logic [DW-1:0] data_word;

    // Handshakes are also gated by clk_en: with the registers frozen, a
    // transfer seen by the neighbour would otherwise be lost or repeated.
    assign data_in_ready  = tile_en && clk_en && (state_q == FILL);
    assign data_out_valid = tile_en && clk_en && dvalid_q;
    assign in_hs          = data_in_valid && data_in_ready;
    assign out_hs         = data_out_valid && data_out_ready;

    assign data_out = dout_q;
    assign overflow = ovf_q;
    assign done     = done_q;

    assign header_word = {{(DW-CW){1'b0}}, count_q};
    assign data_word   = {{(DW-16){1'b0}}, rd_data};

    fib2glb_seg_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk_i    (clk),
        .clk_en_i (clk_en),
        .we_i     (buf_we && !flush),
        .waddr_i  (count_q[AW-1:0]),
        .wdata_i  (data_in[15:0]),
        .raddr_i  (rd_addr),
        .rdata_o  (rd_data)
    );

    // Next-state logic. The output word is registered, so every transition
    // into an emitting state preloads the word that state will present;
    // the read port therefore looks one entry ahead of rd_ptr (or at entry
    // 0 while the header is on the bus).
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        done_d   = done_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        buf_we   = 1'b0;
        rd_addr  = rd_ptr_q[AW-1:0] + AW'(1);

        unique case (state_q)
            FILL: begin
                if (in_hs) begin
                    if (!data_in[FLAG_BIT]) begin
                        if (count_q < DEPTH_C) begin
                            buf_we  = 1'b1;
                            count_d = count_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (data_in == DONE_TOKEN) begin
                        dvalid_d = 1'b1;
                        if (count_q != '0) begin
                            pend_d  = 1'b1;
                            state_d = EMIT_LEN;
                            dout_d  = header_word;
                        end else begin
                            state_d = EMIT_DONE;
                            dout_d  = DONE_TOKEN;
                        end
                    end else if (is_stop(data_in)) begin
                        state_d  = EMIT_LEN;
                        dout_d   = header_word;
                        dvalid_d = 1'b1;
                    end
                end
            end

            EMIT_LEN: begin
                rd_addr = '0;
                if (out_hs) begin
                    if (count_q == '0) begin
                        if (pend_q) begin
                            state_d = EMIT_DONE;
                            dout_d  = DONE_TOKEN;
                        end else begin
                            state_d  = FILL;
                            dout_d   = '0;
                            dvalid_d = 1'b0;
                        end
                    end else begin
                        state_d  = EMIT_DATA;
                        rd_ptr_d = '0;
                        dout_d   = data_word;
                    end
                end
            end

            EMIT_DATA: begin
                if (out_hs) begin
                    if (rd_ptr_q + CW'(1) == count_q) begin
                        count_d  = '0;
                        rd_ptr_d = '0;
                        if (pend_q) begin
                            state_d = EMIT_DONE;
                            dout_d  = DONE_TOKEN;
                        end else begin
                            state_d  = FILL;
                            dout_d   = '0;
                            dvalid_d = 1'b0;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + CW'(1);
                        dout_d   = data_word;
                    end
                end
            end

            EMIT_DONE: begin
                if (out_hs) begin
                    done_d   = 1'b1;
                    pend_d   = 1'b0;
                    state_d  = HALT;
                    dout_d   = '0;
                    dvalid_d = 1'b0;
                end
            end

            HALT: begin
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers: async reset, synchronous flush, both under clk_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            count_q  <= '0;
            rd_ptr_q <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                state_q  <= FILL;
                count_q  <= '0;
                rd_ptr_q <= '0;
                pend_q   <= 1'b0;
                ovf_q    <= 1'b0;
                done_q   <= 1'b0;
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                count_q  <= count_d;
                rd_ptr_q <= rd_ptr_d;
                pend_q   <= pend_d;
                ovf_q    <= ovf_d;
                done_q   <= done_d;
                dout_q   <= dout_d;
                dvalid_q <= dvalid_d;
            end
        end
    end

endmodule

// File: tb/tb_fib2glb_seg_packer.sv
// ---------------------------------------------------------------------------
// tb_fib2glb_seg_packer
//   Directed bench for the segment packer. Inputs change 2 time units after
//   a rising edge; outputs are sampled on the falling edge, so a handshake
//   seen on a falling edge completes on the following rising edge.
// ---------------------------------------------------------------------------
module tb_fib2glb_seg_packer;

    localparam int DEPTH = 64;
    localparam int DW    = 17;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en;
    logic          flush;
    logic          tile_en;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          overflow;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] outQ[$];
    logic          stalled = 1'b0;
    logic [DW-1:0] heldData = '0;
    logic          randReady = 1'b0;
    logic [7:0]    lfsr = 8'hA5;
    int            lowCycles;

    fib2glb_seg_packer #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en         (clk_en),
        .flush          (flush),
        .tile_en        (tile_en),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .overflow       (overflow),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one token and holds it until it is accepted (bounded wait).
    task automatic applyStimulus(input logic [DW-1:0] tok);
        int n = 0;
        data_in       = tok;
        data_in_valid = 1'b1;
        @(negedge clk);
        while (!data_in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) checkOutput("in_timeout", 0, 1);
        @(posedge clk);
        #2;
        data_in_valid = 1'b0;
        data_in       = '0;
    endtask

    // Waits until n output words have been collected (bounded wait).
    task automatic waitOut(input int n);
        int k = 0;
        while (outQ.size() < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (outQ.size() < n) checkOutput("out_timeout", 32'(outQ.size()), 32'(n));
        @(posedge clk);
        #2;
    endtask

    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Output collector, plus a stability check for stalled words.
    always @(negedge clk) begin
        if (rst_n && tile_en) begin
            if (stalled) begin
                checkOutput("stall_valid", 32'(data_out_valid), 1);
                checkOutput("stall_data", 32'(data_out), 32'(heldData));
            end
            if (data_out_valid && data_out_ready) outQ.push_back(data_out);
            stalled  = data_out_valid && !data_out_ready;
            heldData = data_out;
        end else begin
            stalled = 1'b0;
        end
    end

    // Pseudo-random consumer back-pressure from a fixed-seed LFSR.
    always @(posedge clk) begin
        #2;
        if (randReady) begin
            lfsr           = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            data_out_ready = lfsr[0];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        clk_en         = 1'b1;
        flush          = 1'b0;
        tile_en        = 1'b1;
        data_in        = '0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        stepCycles(3);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("rst_ready", 32'(data_in_ready), 1);
        checkOutput("rst_valid", 32'(data_out_valid), 0);
        checkOutput("rst_data", 32'(data_out), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_done", 32'(done), 0);
        @(posedge clk);
        #2;

        // Segment 5,7,9 + stop: header next cycle, words back-to-back
        outQ.delete();
        applyStimulus(17'h00005);
        applyStimulus(17'h00007);
        applyStimulus(17'h00009);
        applyStimulus(17'h10000);
        begin
            logic [DW-1:0] exp1 [4];
            exp1[0] = 17'd3; exp1[1] = 17'd5; exp1[2] = 17'd7; exp1[3] = 17'd9;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checkOutput("seg1_valid", 32'(data_out_valid), 1);
                checkOutput("seg1_data", 32'(data_out), 32'(exp1[i]));
                checkOutput("seg1_busy", 32'(data_in_ready), 0);
            end
        end
        @(negedge clk);
        checkOutput("seg1_ready_back", 32'(data_in_ready), 1);
        checkOutput("seg1_idle", 32'(data_out_valid), 0);
        @(posedge clk);
        #2;

        // Empty segment: header 0, ready low for exactly one cycle
        outQ.delete();
        applyStimulus(17'h10001);
        lowCycles = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!data_in_ready) lowCycles++;
        end
        @(posedge clk);
        #2;
        checkOutput("empty_low_cycles", 32'(lowCycles), 1);
        checkOutput("empty_count", 32'(outQ.size()), 1);
        if (outQ.size() >= 1) checkOutput("empty_hdr", 32'(outQ[0]), 0);

        // Done without stop: 2,4,6,DONE then halt until flush
        outQ.delete();
        applyStimulus(17'h00004);
        applyStimulus(17'h00006);
        applyStimulus(17'h10100);
        waitOut(4);
        begin
            logic [DW-1:0] exp3 [4];
            exp3[0] = 17'd2; exp3[1] = 17'd4; exp3[2] = 17'd6; exp3[3] = 17'h10100;
            for (int i = 0; i < 4; i++) begin
                if (i < outQ.size()) checkOutput("done_seq", 32'(outQ[i]), 32'(exp3[i]));
            end
        end
        stepCycles(3);
        @(negedge clk);
        checkOutput("done_flag", 32'(done), 1);
        checkOutput("halt_ready", 32'(data_in_ready), 0);
        checkOutput("halt_valid", 32'(data_out_valid), 0);
        checkOutput("halt_extra", 32'(outQ.size()), 4);
        @(posedge clk);
        #2;
        flush = 1'b1;
        stepCycles(1);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_ready", 32'(data_in_ready), 1);
        checkOutput("flush_done", 32'(done), 0);
        @(posedge clk);
        #2;

        // Segment 1..10 with random back-pressure
        outQ.delete();
        randReady = 1'b1;
        for (int v = 1; v <= 10; v++) applyStimulus(DW'(v));
        applyStimulus(17'h10000);
        waitOut(11);
        randReady      = 1'b0;
        data_out_ready = 1'b1;
        checkOutput("rand_count", 32'(outQ.size()), 11);
        if (outQ.size() >= 1) checkOutput("rand_hdr", 32'(outQ[0]), 10);
        for (int v = 1; v <= 10; v++) begin
            if (v < outQ.size()) checkOutput("rand_word", 32'(outQ[v]), 32'(v));
        end
        stepCycles(2);
        checkOutput("rand_no_dup", 32'(outQ.size()), 11);

        // Overflow: DEPTH+2 words, only DEPTH kept
        outQ.delete();
        for (int v = 0; v < DEPTH + 2; v++) applyStimulus(DW'(v));
        @(negedge clk);
        checkOutput("ovf_set", 32'(overflow), 1);
        @(posedge clk);
        #2;
        applyStimulus(17'h10000);
        waitOut(DEPTH + 1);
        if (outQ.size() >= 1) checkOutput("ovf_hdr", 32'(outQ[0]), 32'(DEPTH));
        for (int v = 0; v < DEPTH; v++) begin
            if (v + 1 < outQ.size()) checkOutput("ovf_word", 32'(outQ[v+1]), 32'(v));
        end
        stepCycles(3);
        checkOutput("ovf_count", 32'(outQ.size()), 32'(DEPTH + 1));
        @(negedge clk);
        checkOutput("ovf_sticky", 32'(overflow), 1);
        @(posedge clk);
        #2;
        flush = 1'b1;
        stepCycles(1);
        flush = 1'b0;
        @(negedge clk);
        checkOutput("ovf_cleared", 32'(overflow), 0);
        @(posedge clk);
        #2;

        // tile_en low blocks both handshakes
        tile_en = 1'b0;
        @(negedge clk);
        checkOutput("tile_off_ready", 32'(data_in_ready), 0);
        checkOutput("tile_off_valid", 32'(data_out_valid), 0);
        @(posedge clk);
        #2;
        tile_en = 1'b1;

        // Asynchronous reset in the middle of a data burst
        outQ.delete();
        for (int v = 11; v <= 15; v++) applyStimulus(DW'(v));
        applyStimulus(17'h10000);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_rst_valid", 32'(data_out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(data_out_valid), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        outQ.delete();
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(data_in_ready), 1);
        @(posedge clk);
        #2;
        applyStimulus(17'h01234);
        applyStimulus(17'h10000);
        waitOut(2);
        checkOutput("post_rst_count", 32'(outQ.size()), 2);
        if (outQ.size() >= 2) begin
            checkOutput("post_rst_hdr", 32'(outQ[0]), 1);
            checkOutput("post_rst_word", 32'(outQ[1]), 32'h1234);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib2glb_seg_packer.md
Name: fib2glb_seg_packer

Overview:
- Inverse of the GLB-to-fiber segment path. Sits between a read scanner's block-mode output and a GLB-bound tile stream.
- Consumes a 17-bit fiber token stream (data words plus stop/done control tokens).
- Emits each fiber as a length-prefixed segment: first a word count, then the data words in arrival order.
- This segment format is what the write scanner accepts on its block-write input.

Parameters:
- DEPTH, 64, segment buffer capacity in words (power of 2, 2..256)
- DW, 17, token width; bit 16 is the control flag

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  clock enable; all state holds when 0
- flush  in  1  synchronous clear; same effect as reset
- tile_en  in  1  block enable; when 0, data_in_ready=0 and data_out_valid=0, state holds
- data_in  in  DW  token from read scanner
- data_in_valid  in  1  token valid
- data_in_ready  out  1  token accepted when valid&ready
- data_out  out  DW  segment word toward GLB
- data_out_valid  out  1  output valid
- data_out_ready  in  1  consumer ready
- overflow  out  1  sticky: a segment exceeded DEPTH
- done  out  1  done token has been emitted

Behaviour:
- Token classes:
  - data: bit16=0
  - stop: bit16=1 and bits[15:8]=0; stop level in bits[7:0] is ignored
  - done: exactly 17'h10100
  - any other control token: consumed and dropped
- Reset/flush values: state=FILL, count=0, rd_ptr=0, data_in_ready=1 (when tile_en), data_out_valid=0, data_out=0, overflow=0, done=0.
- FILL:
  - data_in_ready=1.
  - Accepted data word: if count<DEPTH, write buf[count] and increment count; otherwise drop the word, set overflow, and hold count at DEPTH.
  - Accepted stop: go to EMIT_LEN.
  - Accepted done: go to EMIT_LEN if count>0 (pending_done=1), else go to EMIT_DONE.
- EMIT_LEN:
  - data_in_ready=0, data_out={1'b0, zero-extended count}, data_out_valid=1.
  - On handshake: if count==0, go to EMIT_DONE when pending_done, else FILL. Otherwise go to EMIT_DATA with rd_ptr=0.
- EMIT_DATA:
  - data_out={1'b0, buf[rd_ptr][15:0]}, valid=1.
  - On handshake, increment rd_ptr. On the handshake where rd_ptr==count-1: clear count, then go to EMIT_DONE if pending_done, else FILL.
- EMIT_DONE: data_out=17'h10100, valid=1. On handshake set done=1 and go to HALT.
- HALT: data_in_ready=0, valid=0. Leaves only on flush or reset.
- Timing:
  - Stop accepted in cycle N gives header valid in cycle N+1.
  - Data words follow back-to-back while data_out_ready=1.
  - The first input is accepted again in the cycle after the last data handshake.
  - Segment throughput: count+1 output cycles plus 1 input cycle for the stop.
- Output registers: data_out and data_out_valid hold stable while valid&!ready. No combinational path from data_out_ready to data_out_valid.
- Input and output handshakes never occur in the same cycle. The buffer is written only in FILL and read only in EMIT_DATA.
- Reset mid-operation: asserting rst_n low drops data_out_valid asynchronously and discards buffered words. flush does the same on the next edge.
- A buffer read of unwritten entries cannot occur (rd_ptr<count always holds).

Decomposition:
- Package fib2glb_pkg: token flag bit index, DONE_TOKEN=17'h10100, a stop-token detect function, and the state enum {FILL, EMIT_LEN, EMIT_DATA, EMIT_DONE, HALT}.
- Sub-module fib2glb_seg_buf: DEPTH x 16 register array with one write port and one combinational read port, with clk_en gating writes. The FSM, counters and output register stay in the top.

Test Plan:
- Data 5, 7, 9, then stop 17'h10000, with ready=1 → out 3, 5, 7, 9 on consecutive cycles. Header valid 1 cycle after the stop is accepted; data_in_ready returns the cycle after 9.
- Immediate stop 17'h10001 → out 0 only; data_in_ready=0 during exactly one cycle.
- Data 4, 6, then 17'h10100 with no stop → out 2, 4, 6, 17'h10100. done=1, then data_in_ready=0 permanently until flush; flush restores ready=1 and done=0.
- Segment 1..10 plus stop, with data_out_ready toggled pseudo-randomly (seed fixed) → out 10, 1..10 in order with no duplicates or drops; data_out stable while stalled.
- DEPTH+2 data words (values 0..65) plus stop with DEPTH=64 → header 64, then words 0..63. overflow=1 and stays set until flush.
- rst_n pulled low during EMIT_DATA of a 5-word segment → data_out_valid=0 immediately. After release: ready=1, next segment 1 word plus stop emits 1, word.
